// File: rtl/rpc2_ctrl_axi_pkg.sv
// rtl/rpc2_ctrl_axi_pkg.sv - shared AXI codes, FSM encoding and width helpers for the rpc2 AXI front end
package rpc2_ctrl_axi_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DATA = 2'd2,
        ST_RESP = 2'd3
    } wr_state_t;

    // Number of byte-offset address bits within one data word (32b -> 2, 64b -> 3).
    function automatic int lsb_bits(input int width);
        return (width == 64) ? 3 : 2;
    endfunction

endpackage

// File: rtl/rpc2_ctrl_axi_wr_strb_gen.sv
// rtl/rpc2_ctrl_axi_wr_strb_gen.sv - first-beat byte-lane mask and clamped size from AW address/size
//
// Ports:
//   addr_lsb  in   LSB      byte offset bits of AWADDR
//   size      in   3        AWSIZE
//   eff_size  out  3        min(size, log2(DATA/8))
//   strb      out  DATA/8   lanes covered by the first beat
module rpc2_ctrl_axi_wr_strb_gen
    import rpc2_ctrl_axi_pkg::*;
#(
    parameter int C_AXI_DATA_WIDTH = 32
) (
    input  logic [lsb_bits(C_AXI_DATA_WIDTH)-1:0] addr_lsb,
    input  logic [2:0]                            size,
    output logic [2:0]                            eff_size,
    output logic [C_AXI_DATA_WIDTH/8-1:0]         strb
);

    localparam int          LSB      = lsb_bits(C_AXI_DATA_WIDTH);
    localparam int          STRB_W   = C_AXI_DATA_WIDTH / 8;
    localparam logic [2:0]  MAX_SIZE = 3'(LSB);

    logic [3:0]     nbytes;
    logic [LSB-1:0] offset;

    always_comb begin
        eff_size = (size > MAX_SIZE) ? MAX_SIZE : size;
        nbytes   = 4'd1 << eff_size;
        // Align the start lane down to the transfer size; an unaligned
        // first beat still only enables the lanes of its aligned container.
        offset   = addr_lsb & ~LSB'(nbytes - 4'd1);
        strb     = '0;
        for (int i = 0; i < STRB_W; i++) begin
            strb[i] = (i >= int'(offset)) && (i < int'(offset) + int'(nbytes));
        end
    end

endmodule

// File: rtl/rpc2_ctrl_axi_wr_burst_control.sv
// rtl/rpc2_ctrl_axi_wr_burst_control.sv - AXI AW/B stage: one outstanding write burst, command push, W ready, posted B
//
// Optional feature macro: WLAST_CHECK_EN (WLAST position check, SLVERR on mismatch).
//
// Ports:
//   clk, reset_n                       clock, asynchronous active-low reset
//   AXI_AW{ID,ADDR,LEN,SIZE,BURST}     AW fields;  AXI_AWVALID / AXI_AWREADY handshake
//   AXI_WVALID, AXI_WLAST              observed W handshake;  AXI_WREADY driven here
//   AXI_BID, AXI_BRESP, AXI_BVALID     B response;  AXI_BREADY from master
//   awcmd_full / awcmd_wr_en / awcmd_din   write-command FIFO interface {id,len,size,burst,addr}
//   wdat_full                          write-data FIFO full (throttles WREADY)
//   wready_req/size/fixed/strb         burst setup to the data stage
//   wready_done                        last beat accepted by the data stage
module rpc2_ctrl_axi_wr_burst_control
    import rpc2_ctrl_axi_pkg::*;
#(
    parameter int C_AXI_ID_WIDTH   = 4,
    parameter int C_AXI_ADDR_WIDTH = 32,
    parameter int C_AXI_DATA_WIDTH = 32,
    parameter int AWCMD_WIDTH      = C_AXI_ID_WIDTH + 8 + 3 + 2 + C_AXI_ADDR_WIDTH
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [C_AXI_ID_WIDTH-1:0]     AXI_AWID,
    input  logic [C_AXI_ADDR_WIDTH-1:0]   AXI_AWADDR,
    input  logic [7:0]                    AXI_AWLEN,
    input  logic [2:0]                    AXI_AWSIZE,
    input  logic [1:0]                    AXI_AWBURST,
    input  logic                          AXI_AWVALID,
    output logic                          AXI_AWREADY,
    input  logic                          AXI_WVALID,
    input  logic                          AXI_WLAST,
    output logic                          AXI_WREADY,
    output logic [C_AXI_ID_WIDTH-1:0]     AXI_BID,
    output logic [1:0]                    AXI_BRESP,
    output logic                          AXI_BVALID,
    input  logic                          AXI_BREADY,
    input  logic                          awcmd_full,
    output logic                          awcmd_wr_en,
    output logic [AWCMD_WIDTH-1:0]        awcmd_din,
    input  logic                          wdat_full,
    output logic                          wready_req,
    output logic [1:0]                    wready_size,
    output logic                          wready_fixed,
    output logic [C_AXI_DATA_WIDTH/8-1:0] wready_strb,
    input  logic                          wready_done
);

    localparam int LSB    = lsb_bits(C_AXI_DATA_WIDTH);
    localparam int STRB_W = C_AXI_DATA_WIDTH / 8;

    wr_state_t state_q, state_d;

    // Held low through reset and for the first cycle after it, so AWREADY
    // reads 0 while reset is asserted even though the state is IDLE.
    logic run_q;

    logic [C_AXI_ID_WIDTH-1:0]   id_q;
    logic [C_AXI_ADDR_WIDTH-1:0] addr_q;
    logic [7:0]                  len_q;
    logic [2:0]                  size_q;
    logic [1:0]                  burst_q;
    logic [1:0]                  wr_size_q;
    logic                        wr_fixed_q;
    logic [STRB_W-1:0]           wr_strb_q;
    logic [7:0]                  beat_q;

    logic [2:0]        gen_eff_size;
    logic [STRB_W-1:0] gen_strb;
    logic              aw_hs;
    logic              w_hs;

    rpc2_ctrl_axi_wr_strb_gen #(
        .C_AXI_DATA_WIDTH (C_AXI_DATA_WIDTH)
    ) u_strb_gen (
        .addr_lsb (AXI_AWADDR[LSB-1:0]),
        .size     (AXI_AWSIZE),
        .eff_size (gen_eff_size),
        .strb     (gen_strb)
    );

    assign aw_hs = AXI_AWVALID & AXI_AWREADY;
    assign w_hs  = AXI_WVALID & AXI_WREADY;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            id_q       <= '0;
            addr_q     <= '0;
            len_q      <= '0;
            size_q     <= '0;
            burst_q    <= '0;
            wr_size_q  <= '0;
            wr_fixed_q <= 1'b0;
            wr_strb_q  <= '0;
        end else if (aw_hs) begin
            id_q       <= AXI_AWID;
            addr_q     <= AXI_AWADDR;
            len_q      <= AXI_AWLEN;
            size_q     <= AXI_AWSIZE;
            burst_q    <= AXI_AWBURST;
            wr_size_q  <= gen_eff_size[1:0];
            wr_fixed_q <= (AXI_AWBURST == BURST_FIXED);
            // WRAP and reserved codes use INCR strobes; the data stage rotates lanes.
            wr_strb_q  <= gen_strb;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            beat_q <= '0;
        end else if (state_q == ST_REQ) begin
            beat_q <= '0;
        end else if (w_hs && beat_q != 8'hFF) begin
            beat_q <= beat_q + 8'd1;
        end
    end

`ifdef WLAST_CHECK_EN
    logic err_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_q <= 1'b0;
        end else if (state_q == ST_REQ) begin
            err_q <= 1'b0;
        end else if (state_q == ST_DATA && w_hs &&
                     (AXI_WLAST != (beat_q == len_q))) begin
            err_q <= 1'b1;
        end
    end
`else
    logic       err_q;
    logic [8:0] unused_wlast_beat;

    assign err_q             = 1'b0;
    assign unused_wlast_beat = {AXI_WLAST, beat_q};
`endif

    logic unused_eff_msb;
    assign unused_eff_msb = gen_eff_size[2];

    always_comb begin
        state_d     = state_q;
        AXI_AWREADY = 1'b0;
        AXI_WREADY  = 1'b0;
        AXI_BVALID  = 1'b0;
        AXI_BRESP   = RESP_OKAY;
        wready_req  = 1'b0;
        awcmd_wr_en = 1'b0;
        case (state_q)
            ST_IDLE: begin
                AXI_AWREADY = run_q & ~awcmd_full;
                if (AXI_AWVALID && run_q && !awcmd_full) begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                wready_req  = 1'b1;
                awcmd_wr_en = 1'b1;
                state_d     = ST_DATA;
            end
            ST_DATA: begin
                AXI_WREADY = ~wdat_full;
                if (wready_done) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                AXI_BVALID = 1'b1;
                AXI_BRESP  = err_q ? RESP_SLVERR : RESP_OKAY;
                if (AXI_BREADY) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign AXI_BID      = id_q;
    assign awcmd_din    = {id_q, len_q, size_q, burst_q, addr_q};
    assign wready_size  = wr_size_q;
    assign wready_fixed = wr_fixed_q;
    assign wready_strb  = wr_strb_q;

endmodule
